// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the pipelined CLA adder/subtractor.
package cla_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic int ngroups(input int width, input int group);
    return width / group;
  endfunction
endpackage

// File: rtl/cla_addsub_pipe_if.sv
// cla_addsub_pipe_if: operand/result handshake bundle for cla_addsub_pipe.
// Optional: CLA_OVERFLOW_FLAG_EN adds the signed-overflow flag ovf.
interface cla_addsub_pipe_if #(parameter int WIDTH = 8);
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [WIDTH-1:0] a, b, sum;
`ifdef CLA_OVERFLOW_FLAG_EN
  logic ovf;
  modport master(output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum, cout, ovf);
  modport slave(input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum, cout, ovf);
`else
  modport master(output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum, cout);
  modport slave(input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/cla_group.sv
// cla_group: GROUP-bit lookahead cell producing group propagate/generate and sum bits.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             cin,
  output logic             gp,
  output logic             gg,
  output logic [GROUP-1:0] sum
);
  logic [GROUP-1:0] c;
  always_comb begin
    c = '0;
    c[0] = cin;
    gp = 1'b1;
    gg = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      if (i < GROUP - 1) c[i+1] = g[i] | (p[i] & c[i]);
      gg = g[i] | (p[i] & gg);
      gp = gp & p[i];
    end
  end
  assign sum = p ^ c;
endmodule

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage pipelined carry-lookahead adder/subtractor, global-stall handshake.
// Optional: define CLA_OVERFLOW_FLAG_EN to add the registered signed-overflow output ovf.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input logic clk,
  input logic rst_n,
  cla_addsub_pipe_if.slave bus
);
  localparam int NG = ngroups(WIDTH, GROUP);
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic             c0;
  } s1_t;
  if (GROUP < 2 || GROUP > 8 || WIDTH < GROUP || WIDTH % GROUP != 0) begin : g_bad_params
    $error("cla_addsub_pipe: WIDTH must be a positive multiple of GROUP, 2 <= GROUP <= 8");
  end
  s1_t s1_d, s1;
  logic s1_v, advance, out_valid, cout;
  logic [WIDTH-1:0] b_eff, p_d, g_d, sum, sum_d, unused_s1_sum;
  logic [NG-1:0] gp_d, gg_d, unused_gp, unused_gg;
  logic [NG:0] gc;
  assign advance = !out_valid || bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = out_valid;
  assign bus.sum = sum;
  assign bus.cout = cout;
  // subtract is a + ~b + 1, so the +1 rides in as the carry-in
  assign b_eff = bus.sub == MODE_SUB ? ~bus.b : bus.b;
  assign p_d = bus.a ^ b_eff;
  assign g_d = bus.a & b_eff;
  assign s1_d = '{p: p_d, g: g_d, gp: gp_d, gg: gg_d, c0: bus.sub == MODE_ADD ? bus.cin : 1'b1};
  always_comb begin
    gc = '0;
    gc[0] = s1.c0;
    for (int i = 0; i < NG; i++) gc[i+1] = s1.gg[i] | (s1.gp[i] & gc[i]);
  end
  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_s1 (
      .p(p_d[k*GROUP +: GROUP]), .g(g_d[k*GROUP +: GROUP]), .cin(1'b0),
      .gp(gp_d[k]), .gg(gg_d[k]), .sum(unused_s1_sum[k*GROUP +: GROUP])
    );
    cla_group #(.GROUP(GROUP)) u_s2 (
      .p(s1.p[k*GROUP +: GROUP]), .g(s1.g[k*GROUP +: GROUP]), .cin(gc[k]),
      .gp(unused_gp[k]), .gg(unused_gg[k]), .sum(sum_d[k*GROUP +: GROUP])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1 <= '0;
      out_valid <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
    end else if (advance) begin
      s1_v <= bus.in_valid;
      s1 <= s1_d;
      out_valid <= s1_v;
      sum <= sum_d;
      cout <= gc[NG];
    end
  end
`ifdef CLA_OVERFLOW_FLAG_EN
  // carry into the MSB is recovered from its sum bit: c = p ^ s
  logic ovf;
  assign bus.ovf = ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else if (advance) ovf <= gc[NG] ^ s1.p[WIDTH-1] ^ sum_d[WIDTH-1];
  end
`endif
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: directed self-checking bench for cla_addsub_pipe (8/4 and 3/3 builds).
// Also checks ovf when CLA_OVERFLOW_FLAG_EN is defined.
module tb_cla_addsub_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  cla_addsub_pipe_if #(.WIDTH(8)) bus8 ();
  cla_addsub_pipe_if #(.WIDTH(3)) bus3 ();
  cla_addsub_pipe #(.WIDTH(8), .GROUP(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  cla_addsub_pipe #(.WIDTH(3), .GROUP(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  logic [7:0] sa [10] = '{8'h00, 8'hFF, 8'h3C, 8'h80, 8'hA5, 8'h01, 8'h7F, 8'hC8, 8'h55, 8'h10};
  logic [7:0] sb [10] = '{8'h00, 8'hFF, 8'hC4, 8'h80, 8'h5A, 8'h02, 8'h80, 8'h37, 8'hAA, 8'h10};
  logic       sc [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       ss [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    bus8.in_valid = v;
    bus8.a = a;
    bus8.b = b;
    bus8.cin = c;
    bus8.sub = s;
  endtask
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic s, input logic [7:0] es, input logic ec);
    set8(1'b1, a, b, c, s);
    tick();
    set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check({tag, "_lat"}, 32'(bus8.out_valid), 32'd0);
    tick();
    check({tag, "_v"}, 32'(bus8.out_valid), 32'd1);
    check({tag, "_sum"}, 32'(bus8.sum), 32'(es));
    check({tag, "_cout"}, 32'(bus8.cout), 32'(ec));
  endtask
  initial begin
    logic [8:0] m;
    set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    bus8.out_ready = 1'b1;
    bus3.in_valid = 1'b0;
    bus3.a = 3'd0;
    bus3.b = 3'd0;
    bus3.cin = 1'b0;
    bus3.sub = 1'b0;
    bus3.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_sum", 32'(bus8.sum), 32'd0);
    check("rst_cout", 32'(bus8.cout), 32'd0);
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    check("rst_valid3", 32'(bus3.out_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_valid", 32'(bus8.out_valid), 32'd0);
    run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    run8("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1);
    run8("sub_cin_ign", 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1);
    run8("add_cin", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0);
    run8("add_wrap", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    // back-to-back stream: one result per cycle, checked in order
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) set8(1'b1, sa[i], sb[i], sc[i], ss[i]);
      else set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      tick();
      if (i > 0) begin
        m = ss[i-1] ? {1'b0, sa[i-1]} + {1'b0, ~sb[i-1]} + 9'd1
                    : {1'b0, sa[i-1]} + {1'b0, sb[i-1]} + {8'd0, sc[i-1]};
        check("stream_v", 32'(bus8.out_valid), 32'd1);
        check("stream_sum", 32'(bus8.sum), 32'(m[7:0]));
        check("stream_cout", 32'(bus8.cout), 32'(m[8]));
      end
    end
    tick();
    check("stream_end", 32'(bus8.out_valid), 32'd0);
    // backpressure: three ops pushed while the consumer stalls
    bus8.out_ready = 1'b0;
    set8(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
    tick();
    check("stall_rdy0", 32'(bus8.in_ready), 32'd1);
    set8(1'b1, 8'h10, 8'h01, 1'b0, 1'b1);
    tick();
    check("stall_rdy1", 32'(bus8.in_ready), 32'd0);
    check("stall_v", 32'(bus8.out_valid), 32'd1);
    set8(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_sum", 32'(bus8.sum), 32'h03);
      check("hold_cout", 32'(bus8.cout), 32'd0);
      check("hold_v", 32'(bus8.out_valid), 32'd1);
      check("hold_rdy", 32'(bus8.in_ready), 32'd0);
    end
    bus8.out_ready = 1'b1;
    tick();
    set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("drain1_v", 32'(bus8.out_valid), 32'd1);
    check("drain1_sum", 32'(bus8.sum), 32'h0F);
    check("drain1_cout", 32'(bus8.cout), 32'd1);
    tick();
    check("drain2_v", 32'(bus8.out_valid), 32'd1);
    check("drain2_sum", 32'(bus8.sum), 32'h00);
    check("drain2_cout", 32'(bus8.cout), 32'd1);
    tick();
    check("drain_end", 32'(bus8.out_valid), 32'd0);
    // asynchronous reset with two ops in flight
    set8(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
    tick();
    set8(1'b1, 8'h33, 8'h44, 1'b0, 1'b0);
    tick();
    set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("inflight_sum", 32'(bus8.sum), 32'h33);
    rst_n = 1'b0;
    #1;
    check("rst_async_v", 32'(bus8.out_valid), 32'd0);
    check("rst_async_sum", 32'(bus8.sum), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_stale", 32'(bus8.out_valid), 32'd0);
    end
    bus3.in_valid = 1'b1;
    bus3.a = 3'b111;
    bus3.b = 3'b001;
    bus3.cin = 1'b1;
    tick();
    bus3.in_valid = 1'b0;
    tick();
    check("w3_v", 32'(bus3.out_valid), 32'd1);
    check("w3_sum", 32'(bus3.sum), 32'd1);
    check("w3_cout", 32'(bus3.cout), 32'd1);
`ifdef CLA_OVERFLOW_FLAG_EN
    run8("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0);
    check("ovf_7f_01_flag", 32'(bus8.ovf), 32'd1);
    run8("ovf_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1);
    check("ovf_80_01_flag", 32'(bus8.ovf), 32'd1);
    run8("ovf_10_20", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0);
    check("ovf_10_20_flag", 32'(bus8.ovf), 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
